// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential 32x32 multiplier.
package mul_pkg;
    localparam int MUL_W = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;
endpackage

// File: rtl/fulladder32.sv
// 32-bit ripple-carry adder: {c,s} = a + b + pin.
module fulladder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        pin,
    output logic [31:0] s,
    output logic        c
);
    logic [32:0] cy;

    assign cy[0] = pin;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign s[i]    = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end

    assign c = cy[32];
endmodule

// File: rtl/seq_multiplier32.sv
// Multi-cycle unsigned 32x32->64 shift-and-add multiplier, one adder pass per clock.
module seq_multiplier32
    import mul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MUL_W-1:0]     a,
    input  logic [MUL_W-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*MUL_W-1:0]   product
);
    mul_state_t state, state_nxt;

    logic [MUL_W-1:0] m, p_hi, p_lo;
    logic [CNT_W-1:0] cnt;
    logic [MUL_W-1:0] addend, sum;
    logic             cout;
    logic [2*MUL_W-1:0] shifted;

    assign addend  = p_lo[0] ? m : '0;
    // Carry-out becomes the new MSB, so the 65-bit right shift never loses a bit.
    assign shifted = {cout, sum, p_lo[MUL_W-1:1]};

    fulladder32 u_add (
        .a   (p_hi),
        .b   (addend),
        .pin (1'b0),
        .s   (sum),
        .c   (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_CALC;
            S_CALC: begin
                busy = 1'b1;
                if (cnt == LAST_ITER) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    m    <= a;
                    p_hi <= '0;
                    p_lo <= b;
                    cnt  <= '0;
                end
                S_CALC: begin
                    {p_hi, p_lo} <= shifted;
                    cnt          <= cnt + 5'd1;
                    if (cnt == LAST_ITER) product <= shifted;
                end
                default: ;
            endcase
        end
    end
endmodule
